// File: rtl/comp_multiplier.sv
// Sequential shift-add WIDTH x WIDTH multiplier, one partial-product step per clock, Run/Ready four-phase handshake.
// Optional macro SIGNED_MULT_EN: two's-complement operands via magnitude datapath plus final conditional negate.
module comp_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [WIDTH-1:0]     Multiplicand_in,
  input  logic [WIDTH-1:0]     Multiplier_in,
  output logic [2*WIDTH-1:0]   Product_out,
  output logic                 Ready,
  output logic [WIDTH-1:0]     ALU_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_p;
  logic [2*WIDTH-1:0] final_p;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  // Carry out of the upper-half add is kept by shifting it into bit 2W-1.
  assign step_sum  = {1'b0, Product_out[2*WIDTH-1:WIDTH]}
                   + (Product_out[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign step_p    = {step_sum, Product_out[WIDTH-1:1]};
  assign last_step = (state == CALC) && (cnt == LAST_CNT);
  assign ALU_result = Product_out[2*WIDTH-1:WIDTH] + mcand;

`ifdef SIGNED_MULT_EN
  logic sign_q;
  logic sign_d;

  // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign op_a    = Multiplicand_in[WIDTH-1] ? (~Multiplicand_in + WIDTH'(1)) : Multiplicand_in;
  assign op_b    = Multiplier_in[WIDTH-1]   ? (~Multiplier_in + WIDTH'(1))   : Multiplier_in;
  assign sign_d  = Multiplicand_in[WIDTH-1] ^ Multiplier_in[WIDTH-1];
  assign final_p = sign_q ? (-step_p) : step_p;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sign_q <= 1'b0;
    end else if ((state == IDLE) && Run) begin
      sign_q <= sign_d;
    end
  end
`else
  assign op_a    = Multiplicand_in;
  assign op_b    = Multiplier_in;
  assign final_p = step_p;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Run) state_nxt = CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      Product_out <= '0;
      mcand       <= '0;
      cnt         <= '0;
      Ready       <= 1'b0;
    end else begin
      Ready <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (Run) begin
            mcand       <= op_a;
            Product_out <= {{WIDTH{1'b0}}, op_b};
            cnt         <= '0;
          end
        end
        CALC: begin
          cnt         <= cnt + 1'b1;
          Product_out <= last_step ? final_p : step_p;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
